// File: rtl/align_pkg.sv
// Shared types and defaults for the 64b/66b block-alignment controller.
// Imported by the window monitor and the top-level sequencer.
package align_pkg;

  localparam int POS_W = 7;

  localparam int MAX_POS_D        = 65;
  localparam int LOCK_COUNT_D     = 64;
  localparam int WINDOW_D         = 1024;
  localparam int UNLOCK_THRESH_D  = 16;
  localparam int RST_CYCLES_D     = 4;
  localparam int SEARCH_TIMEOUT_D = 4096;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_VERIFY  = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_RESTART = 2'd3
  } state_e;

endpackage

// File: rtl/align_lock_ctrl_mon.sv
// Header window monitor: sample and error counters with threshold, window-end
// and good-run detection. Flags are combinational on the current sample.
module lock_window_mon
  import align_pkg::*;
#(
  parameter int WINDOW = WINDOW_D,
  parameter int THRESH = UNLOCK_THRESH_D,
  parameter int GOOD   = LOCK_COUNT_D
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic sample_i,
  input  logic invalid_i,
  output logic thresh_hit_o,
  output logic good_hit_o
);

  localparam int WW = $clog2(WINDOW + 1);
  localparam int BW = $clog2(THRESH + 1);

  logic [WW-1:0] win_q, win_d;
  logic [BW-1:0] bad_q, bad_d;
  logic          win_end;

  assign win_end = sample_i && (win_q == WW'(WINDOW - 1));
  assign good_hit_o = sample_i && (win_q == WW'(GOOD - 1));
  assign thresh_hit_o = sample_i && invalid_i &&
                        (bad_q == BW'(THRESH - 1));

  always_comb begin
    win_d = win_q;
    bad_d = bad_q;
    if (clear_i || win_end) begin
      win_d = '0;
      bad_d = '0;
    end else if (sample_i) begin
      win_d = win_q + 1'b1;
      if (invalid_i) begin
        bad_d = bad_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q <= '0;
      bad_q <= '0;
    end else begin
      win_q <= win_d;
      bad_q <= bad_d;
    end
  end

endmodule

// File: rtl/align_lock_ctrl.sv
// Block-alignment sequencer: restarts the seeker tree, captures its offset,
// verifies sync headers at that offset and monitors them once locked.
module align_lock_ctrl
  import align_pkg::*;
#(
  parameter int MAX_POS        = MAX_POS_D,
  parameter int LOCK_COUNT     = LOCK_COUNT_D,
  parameter int WINDOW         = WINDOW_D,
  parameter int UNLOCK_THRESH  = UNLOCK_THRESH_D,
  parameter int RST_CYCLES     = RST_CYCLES_D,
  parameter int SEARCH_TIMEOUT = SEARCH_TIMEOUT_D
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             buffer_dv_i,
  input  logic             seeker_synced_i,
  input  logic [POS_W-1:0] seeker_pos_i,
  input  logic             hdr_dv_i,
  input  logic             hdr_ok_i,
  input  logic             force_resync_i,
  output logic             seeker_rst_o,
  output logic             locked_o,
  output logic [POS_W-1:0] lock_pos_o,
  output logic [1:0]       state_o,
  output logic [7:0]       relock_cnt_o
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(SEARCH_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [7:0]       relock_q, relock_d;
  logic             srst_q, locked_q;

  logic mon_clear, mon_sample, mon_invalid;
  logic thresh_hit, good_hit;
  logic hdr_bad, capture;

  assign hdr_bad = hdr_dv_i && !hdr_ok_i;
  assign capture = buffer_dv_i && seeker_synced_i &&
                   (seeker_pos_i <= POS_W'(MAX_POS));

  // VERIFY counts only good headers; LOCKED counts all, errors separately.
  assign mon_sample = hdr_dv_i &&
    ((state_q == ST_VERIFY && hdr_ok_i) || state_q == ST_LOCKED);
  assign mon_invalid = (state_q == ST_LOCKED) && hdr_bad;
  assign mon_clear = (state_d != state_q) ||
                     (state_q == ST_SEARCH) ||
                     (state_q == ST_RESTART);

  lock_window_mon #(
    .WINDOW (WINDOW),
    .THRESH (UNLOCK_THRESH),
    .GOOD   (LOCK_COUNT)
  ) u_mon (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (mon_clear),
    .sample_i     (mon_sample),
    .invalid_i    (mon_invalid),
    .thresh_hit_o (thresh_hit),
    .good_hit_o   (good_hit)
  );

  always_comb begin
    state_d = state_q;
    rcnt_d  = '0;
    tcnt_d  = '0;
    pos_d   = pos_q;
    unique case (state_q)
      ST_RESTART: begin
        if (force_resync_i) begin
          rcnt_d = '0;
        end else if (rcnt_q == RW'(RST_CYCLES - 1)) begin
          state_d = ST_SEARCH;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      ST_SEARCH: begin
        if (force_resync_i) begin
          state_d = ST_RESTART;
        end else if (capture) begin
          pos_d   = seeker_pos_i;
          state_d = ST_VERIFY;
        end else if (buffer_dv_i) begin
          if (tcnt_q == TW'(SEARCH_TIMEOUT - 1)) begin
            state_d = ST_RESTART;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      ST_VERIFY: begin
        if (force_resync_i || hdr_bad) begin
          state_d = ST_RESTART;
        end else if (good_hit) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (force_resync_i || thresh_hit) begin
          state_d = ST_RESTART;
        end
      end
      default: state_d = ST_RESTART;
    endcase
  end

  always_comb begin
    relock_d = relock_q;
    if (state_d == ST_RESTART && state_q != ST_RESTART &&
        relock_q != 8'hFF) begin
      relock_d = relock_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_RESTART;
      rcnt_q   <= '0;
      tcnt_q   <= '0;
      pos_q    <= '0;
      relock_q <= '0;
      srst_q   <= 1'b1;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      tcnt_q   <= tcnt_d;
      pos_q    <= pos_d;
      relock_q <= relock_d;
      srst_q   <= (state_d == ST_RESTART);
      locked_q <= (state_d == ST_LOCKED);
    end
  end

  assign seeker_rst_o = srst_q;
  assign locked_o     = locked_q;
  assign lock_pos_o   = pos_q;
  assign state_o      = state_q;
  assign relock_cnt_o = relock_q;

endmodule

// File: tb/tb_align_lock_ctrl.sv
// Scoreboard bench for align_lock_ctrl: expectations queued with stimulus,
// popped and compared on the falling edge after the DUT responds.
module tb_align_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  logic       buffer_dv = 1'b0;
  logic       synced = 1'b0;
  logic [6:0] pos = '0;
  logic       hdr_dv = 1'b0;
  logic       hdr_ok = 1'b0;
  logic       force_rs = 1'b0;
  logic       seeker_rst_o;
  logic       locked_o;
  logic [6:0] lock_pos_o;
  logic [1:0] state_o;
  logic [7:0] relock_cnt_o;

  int checks = 0;
  int errors = 0;
  int exp_relock = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  align_lock_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .buffer_dv_i     (buffer_dv),
    .seeker_synced_i (synced),
    .seeker_pos_i    (pos),
    .hdr_dv_i        (hdr_dv),
    .hdr_ok_i        (hdr_ok),
    .force_resync_i  (force_rs),
    .seeker_rst_o    (seeker_rst_o),
    .locked_o        (locked_o),
    .lock_pos_o      (lock_pos_o),
    .state_o         (state_o),
    .relock_cnt_o    (relock_cnt_o)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_rst_done(output int n);
    n = 0;
    while (seeker_rst_o === 1'b1 && n < 64) begin
      n++;
      tick();
    end
  endtask

  task automatic capture(input logic [6:0] p);
    buffer_dv = 1'b1;
    synced = 1'b1;
    pos = p;
    tick();
    buffer_dv = 1'b0;
    synced = 1'b0;
  endtask

  task automatic feed(input int n, input logic ok);
    hdr_dv = 1'b1;
    hdr_ok = ok;
    repeat (n) tick();
    hdr_dv = 1'b0;
    hdr_ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    #1 rst_ni = 1'b0;
    tick();
    tick();
    exp_q.push_back(3);
    exp_q.push_back(1);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    e = exp_q.pop_front(); checks++;
    if (state_o !== e[1:0]) begin
      errors++; $display("FAIL rst_state: got %0d want %0d", state_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (seeker_rst_o !== e[0]) begin
      errors++; $display("FAIL rst_seeker: got %0b want %0d", seeker_rst_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (locked_o !== e[0]) begin
      errors++; $display("FAIL rst_locked: got %0b want %0d", locked_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (lock_pos_o !== e[6:0]) begin
      errors++; $display("FAIL rst_pos: got %0d want %0d", lock_pos_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (relock_cnt_o !== e[7:0]) begin
      errors++; $display("FAIL rst_relock: got %0d want %0d", relock_cnt_o, e);
    end
  endtask

  task automatic test_search_capture();
    logic [31:0] e;
    int n;
    buffer_dv = 1'b1;
    synced = 1'b1;
    pos = 7'd37;
    rst_ni = 1'b1;
    exp_q.push_back(4);
    wait_rst_done(n);
    e = exp_q.pop_front(); checks++;
    if (n !== int'(e)) begin
      errors++; $display("FAIL first_pulse: got %0d want %0d", n, e);
    end
    exp_q.push_back(0);
    e = exp_q.pop_front(); checks++;
    if (state_o !== e[1:0]) begin
      errors++; $display("FAIL search_state: got %0d want %0d", state_o, e);
    end
    exp_q.push_back(1);
    exp_q.push_back(37);
    capture(7'd37);
    e = exp_q.pop_front(); checks++;
    if (state_o !== e[1:0]) begin
      errors++; $display("FAIL capture_state: got %0d want %0d", state_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (lock_pos_o !== e[6:0]) begin
      errors++; $display("FAIL capture_pos: got %0d want %0d", lock_pos_o, e);
    end
  endtask

  task automatic test_verify_lock();
    logic [31:0] e;
    int lock_at = 0;
    exp_q.push_back(64);
    exp_q.push_back(2);
    exp_q.push_back(exp_relock);
    hdr_dv = 1'b1;
    hdr_ok = 1'b1;
    for (int i = 1; i <= 80 && lock_at == 0; i++) begin
      tick();
      if (locked_o === 1'b1) lock_at = i;
    end
    hdr_dv = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (lock_at !== int'(e)) begin
      errors++; $display("FAIL lock_latency: got %0d want %0d", lock_at, e);
    end
    e = exp_q.pop_front(); checks++;
    if (state_o !== e[1:0]) begin
      errors++; $display("FAIL lock_state: got %0d want %0d", state_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (relock_cnt_o !== e[7:0]) begin
      errors++; $display("FAIL lock_relock: got %0d want %0d", relock_cnt_o, e);
    end
  endtask

  task automatic test_locked_window();
    logic [31:0] e;
    int n;
    hdr_dv = 1'b1;
    for (int w = 0; w < 3; w++) begin
      exp_q.push_back(1);
      for (int i = 0; i < 1024; i++) begin
        hdr_ok = !(i >= 100 && i < 115);
        tick();
      end
      e = exp_q.pop_front(); checks++;
      if (locked_o !== e[0]) begin
        errors++; $display("FAIL win15_locked w%0d: got %0b want %0d", w, locked_o, e);
      end
    end
    exp_q.push_back(1);
    exp_q.push_back(3);
    exp_q.push_back(0);
    hdr_ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 14) begin
        e = exp_q.pop_front(); checks++;
        if (locked_o !== e[0]) begin
          errors++; $display("FAIL bad15_locked: got %0b want %0d", locked_o, e);
        end
      end
    end
    hdr_dv = 1'b0;
    exp_relock++;
    exp_q.push_back(exp_relock);
    e = exp_q.pop_front(); checks++;
    if (state_o !== e[1:0]) begin
      errors++; $display("FAIL unlock_state: got %0d want %0d", state_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (locked_o !== e[0]) begin
      errors++; $display("FAIL unlock_locked: got %0b want %0d", locked_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (relock_cnt_o !== e[7:0]) begin
      errors++; $display("FAIL unlock_relock: got %0d want %0d", relock_cnt_o, e);
    end
    exp_q.push_back(4);
    wait_rst_done(n);
    e = exp_q.pop_front(); checks++;
    if (n !== int'(e)) begin
      errors++; $display("FAIL unlock_pulse: got %0d want %0d", n, e);
    end
  endtask

  task automatic test_verify_fail();
    logic [31:0] e;
    int n;
    logic saw_lock = 1'b0;
    exp_q.push_back(12);
    capture(7'd12);
    e = exp_q.pop_front(); checks++;
    if (lock_pos_o !== e[6:0]) begin
      errors++; $display("FAIL vfail_pos: got %0d want %0d", lock_pos_o, e);
    end
    hdr_dv = 1'b1;
    hdr_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (locked_o !== 1'b0) saw_lock = 1'b1;
    end
    hdr_ok = 1'b0;
    tick();
    hdr_dv = 1'b0;
    if (locked_o !== 1'b0) saw_lock = 1'b1;
    exp_relock++;
    exp_q.push_back(3);
    exp_q.push_back(exp_relock);
    exp_q.push_back(0);
    e = exp_q.pop_front(); checks++;
    if (state_o !== e[1:0]) begin
      errors++; $display("FAIL vfail_state: got %0d want %0d", state_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (relock_cnt_o !== e[7:0]) begin
      errors++; $display("FAIL vfail_relock: got %0d want %0d", relock_cnt_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (saw_lock !== e[0]) begin
      errors++; $display("FAIL vfail_nolock: got %0b want %0d", saw_lock, e);
    end
    exp_q.push_back(4);
    wait_rst_done(n);
    e = exp_q.pop_front(); checks++;
    if (n !== int'(e)) begin
      errors++; $display("FAIL vfail_pulse: got %0d want %0d", n, e);
    end
  endtask

  task automatic test_thresh_coincide();
    logic [31:0] e;
    int n;
    capture(7'd20);
    feed(64, 1'b1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    hdr_dv = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      hdr_ok = (i < 1008);
      tick();
      if (i == 1022) begin
        e = exp_q.pop_front(); checks++;
        if (state_o !== e[1:0]) begin
          errors++; $display("FAIL coin_pre_state: got %0d want %0d", state_o, e);
        end
      end
    end
    hdr_dv = 1'b0;
    exp_relock++;
    e = exp_q.pop_front(); checks++;
    if (state_o !== e[1:0]) begin
      errors++; $display("FAIL coin_state: got %0d want %0d", state_o, e);
    end
    exp_q.push_back(exp_relock);
    e = exp_q.pop_front(); checks++;
    if (relock_cnt_o !== e[7:0]) begin
      errors++; $display("FAIL coin_relock: got %0d want %0d", relock_cnt_o, e);
    end
    wait_rst_done(n);
  endtask

  task automatic test_search_timeout();
    logic [31:0] e;
    int n;
    exp_q.push_back(0);
    exp_q.push_back(3);
    buffer_dv = 1'b1;
    synced = 1'b0;
    repeat (4095) tick();
    e = exp_q.pop_front(); checks++;
    if (state_o !== e[1:0]) begin
      errors++; $display("FAIL to_pre_state: got %0d want %0d", state_o, e);
    end
    tick();
    buffer_dv = 1'b0;
    exp_relock++;
    e = exp_q.pop_front(); checks++;
    if (state_o !== e[1:0]) begin
      errors++; $display("FAIL to_state: got %0d want %0d", state_o, e);
    end
    exp_q.push_back(exp_relock);
    e = exp_q.pop_front(); checks++;
    if (relock_cnt_o !== e[7:0]) begin
      errors++; $display("FAIL to_relock: got %0d want %0d", relock_cnt_o, e);
    end
    wait_rst_done(n);
    exp_q.push_back(0);
    exp_q.push_back(20);
    buffer_dv = 1'b1;
    synced = 1'b1;
    pos = 7'd70;
    repeat (10) tick();
    e = exp_q.pop_front(); checks++;
    if (state_o !== e[1:0]) begin
      errors++; $display("FAIL pos70_state: got %0d want %0d", state_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (lock_pos_o !== e[6:0]) begin
      errors++; $display("FAIL pos70_held: got %0d want %0d", lock_pos_o, e);
    end
    exp_q.push_back(1);
    exp_q.push_back(65);
    capture(7'd65);
    e = exp_q.pop_front(); checks++;
    if (state_o !== e[1:0]) begin
      errors++; $display("FAIL pos65_state: got %0d want %0d", state_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (lock_pos_o !== e[6:0]) begin
      errors++; $display("FAIL pos65_pos: got %0d want %0d", lock_pos_o, e);
    end
  endtask

  task automatic test_force_resync();
    logic [31:0] e;
    int n;
    logic held_ok = 1'b1;
    feed(64, 1'b1);
    exp_q.push_back(1);
    e = exp_q.pop_front(); checks++;
    if (locked_o !== e[0]) begin
      errors++; $display("FAIL frc_pre_lock: got %0b want %0d", locked_o, e);
    end
    force_rs = 1'b1;
    tick();
    force_rs = 1'b0;
    exp_relock++;
    exp_q.push_back(3);
    exp_q.push_back(0);
    exp_q.push_back(exp_relock);
    e = exp_q.pop_front(); checks++;
    if (state_o !== e[1:0]) begin
      errors++; $display("FAIL frc_state: got %0d want %0d", state_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (locked_o !== e[0]) begin
      errors++; $display("FAIL frc_locked: got %0b want %0d", locked_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (relock_cnt_o !== e[7:0]) begin
      errors++; $display("FAIL frc_relock: got %0d want %0d", relock_cnt_o, e);
    end
    wait_rst_done(n);
    force_rs = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (seeker_rst_o !== 1'b1 || state_o !== 2'd3) held_ok = 1'b0;
    end
    force_rs = 1'b0;
    exp_relock++;
    exp_q.push_back(1);
    exp_q.push_back(4);
    exp_q.push_back(exp_relock);
    e = exp_q.pop_front(); checks++;
    if (held_ok !== e[0]) begin
      errors++; $display("FAIL frc_hold: got %0b want %0d", held_ok, e);
    end
    wait_rst_done(n);
    e = exp_q.pop_front(); checks++;
    if (n !== int'(e)) begin
      errors++; $display("FAIL frc_hold_pulse: got %0d want %0d", n, e);
    end
    e = exp_q.pop_front(); checks++;
    if (relock_cnt_o !== e[7:0]) begin
      errors++; $display("FAIL frc_hold_relock: got %0d want %0d", relock_cnt_o, e);
    end
  endtask

  task automatic test_relock_saturate();
    logic [31:0] e;
    int n;
    for (int i = 0; i < 300; i++) begin
      force_rs = 1'b1;
      tick();
      force_rs = 1'b0;
      if (exp_relock < 255) exp_relock++;
      wait_rst_done(n);
    end
    exp_q.push_back(exp_relock);
    e = exp_q.pop_front(); checks++;
    if (relock_cnt_o !== e[7:0]) begin
      errors++; $display("FAIL relock_sat: got %0d want %0d", relock_cnt_o, e);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    capture(7'd33);
    feed(5, 1'b1);
    exp_q.push_back(1);
    e = exp_q.pop_front(); checks++;
    if (state_o !== e[1:0]) begin
      errors++; $display("FAIL arst_pre_state: got %0d want %0d", state_o, e);
    end
    exp_q.push_back(3);
    exp_q.push_back(1);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    #2 rst_ni = 1'b0;
    #1;
    e = exp_q.pop_front(); checks++;
    if (state_o !== e[1:0]) begin
      errors++; $display("FAIL arst_state: got %0d want %0d", state_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (seeker_rst_o !== e[0]) begin
      errors++; $display("FAIL arst_seeker: got %0b want %0d", seeker_rst_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (locked_o !== e[0]) begin
      errors++; $display("FAIL arst_locked: got %0b want %0d", locked_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (lock_pos_o !== e[6:0]) begin
      errors++; $display("FAIL arst_pos: got %0d want %0d", lock_pos_o, e);
    end
    e = exp_q.pop_front(); checks++;
    if (relock_cnt_o !== e[7:0]) begin
      errors++; $display("FAIL arst_relock: got %0d want %0d", relock_cnt_o, e);
    end
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_search_capture();
    test_verify_lock();
    test_locked_window();
    test_verify_fail();
    test_thresh_coincide();
    test_search_timeout();
    test_force_resync();
    test_relock_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
